fifo_port_arbiter: RTL and testbench

- Shares one FIFO instance between two producers and one consumer.
- Write side: round-robin arbitration of two request/grant producers onto the FIFO write strobe and input bus, with backpressure on full.
- Read side: sequencer FSM that waits out RAM read latency, pops one word, and presents it on a valid/ready output register.
- Sits between the producers/consumer and the FIFO top level.

---
 rtl/fifo_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_arbiter.sv
// Two-producer round-robin write arbiter and settle/pop/hold read sequencer for one shared FIFO.
// Optional grant/stall statistics outputs are enabled with `define ARB_STATS_EN.
module fifo_port_arbiter #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2   // head-settle cycles before a pop, 1..7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_write,
  output logic [WIDTH-1:0] fifo_wdata,
  output logic             fifo_read,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
`ifdef ARB_STATS_EN
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
  output logic [15:0]      stall_cnt,
`endif
  input  logic             out_ready
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_POP,
    S_HOLD
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last_gnt;

  // Write arbitration: the requester that did not win last time takes a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset && !fifo_full) begin
      if (req0 && (!req1 || last_gnt))
        gnt0 = 1'b1;
      else if (req1)
        gnt1 = 1'b1;
    end
  end

  assign fifo_write = gnt0 | gnt1;
  assign fifo_wdata = gnt0 ? data0 : (gnt1 ? data1 : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_gnt <= 1'b1;
    else if (gnt0 || gnt1)
      last_gnt <= gnt1;
  end

  // Read sequencer: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fifo_read = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = CNT_W'(SETTLE - 1);
        end
      end
      S_SETTLE: begin
        if (fifo_empty)
          state_nxt = S_IDLE;
        else if (cnt == '0)
          state_nxt = S_POP;
        else
          cnt_nxt = cnt - 3'd1;
      end
      S_POP: begin
        // A head that vanished under us is not popped; go back and wait
        fifo_read = !fifo_empty;
        state_nxt = fifo_empty ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (out_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output register: captured on the pop cycle, released on consumer accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fifo_read) begin
      out_valid <= 1'b1;
      out_data  <= fifo_rdata;
    end else if (state == S_HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0      <= '0;
      cnt1      <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt0)
        cnt0 <= sat_inc(cnt0);
      if (gnt1)
        cnt1 <= sat_inc(cnt1);
      if ((req0 || req1) && fifo_full)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed self-checking bench for fifo_port_arbiter with a small behavioural FIFO attached.
// Statistics checks are compiled in when ARB_STATS_EN is defined.
module tb_fifo_port_arbiter;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_write;
  logic [WIDTH-1:0] fifo_wdata;
  logic             fifo_read;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef ARB_STATS_EN
  logic [15:0]      cnt0, cnt1, stall_cnt;
`endif

  logic             force_full;
  logic             flush;
  logic [WIDTH-1:0] mem [16];
  logic [4:0]       wp = '0;
  logic [4:0]       rp = '0;

  int n_checks = 0;
  int n_errors = 0;

  fifo_port_arbiter #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .data0      (data0),
    .gnt0       (gnt0),
    .req1       (req1),
    .data1      (data1),
    .gnt1       (gnt1),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_write (fifo_write),
    .fifo_wdata (fifo_wdata),
    .fifo_read  (fifo_read),
    .out_valid  (out_valid),
    .out_data   (out_data),
`ifdef ARB_STATS_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .stall_cnt  (stall_cnt),
`endif
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16-deep FIFO with a combinational head word
  always @(posedge clk) begin
    if (fifo_write && !fifo_full) begin
      mem[wp[3:0]] <= fifo_wdata;
      wp <= wp + 5'd1;
    end
    if (flush)
      rp <= wp;
    else if (fifo_read && !fifo_empty)
      rp <= rp + 5'd1;
  end

  assign fifo_empty = (wp == rp);
  assign fifo_full  = force_full || ((wp - rp) == 5'd16);
  assign fifo_rdata = mem[rp[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    flush = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    out_ready = 1'b0;
    force_full = 1'b0;
    next_cycle();
    flush = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int reads;
    int hold_cycles;
    int stable_bad;
    int cyc;
    bit seen;
    logic [WIDTH-1:0] hold_val;
    logic [WIDTH-1:0] got[$];
    int pops[$];
    int exp_w[4] = '{1, 2, 1, 2};
    logic [3:0] exp_g0 = 4'b0101;

    // Reset state, with a request already pending
    reset = 1'b0; flush = 1'b1; force_full = 1'b0; out_ready = 1'b0;
    req0 = 1'b1; data0 = 4'hA; req1 = 1'b0; data1 = '0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_fifo_read", 32'(fifo_read), 0);
    check("rst_gnt0", 32'(gnt0), 0);
    check("rst_fifo_write", 32'(fifo_write), 0);
    next_cycle();
    flush = 1'b0;
    reset = 1'b1;

    // Single write into an empty FIFO, then latency to out_valid
    @(negedge clk);
    check("t1_gnt0", 32'(gnt0), 1);
    check("t1_gnt1", 32'(gnt1), 0);
    check("t1_write", 32'(fifo_write), 1);
    check("t1_wdata", 32'(fifo_wdata), 32'hA);
    next_cycle();
    req0 = 1'b0;
    reads = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (fifo_read) reads++;
      if (k == 4) begin
        check("t1_pop_read", 32'(fifo_read), 1);
        check("t1_pop_valid", 32'(out_valid), 0);
      end
      if (k == 5) begin
        check("t1_valid", 32'(out_valid), 1);
        check("t1_data", 32'(out_data), 32'hA);
      end
      if (k < 5) next_cycle();
    end
    check("t1_reads", reads, 1);
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("t1_accept_valid", 32'(out_valid), 0);

    // Tie between producers alternates starting with producer 0
    do_reset();
    req0 = 1'b1; data0 = 4'h1;
    req1 = 1'b1; data1 = 4'h2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_gnt0", 32'(gnt0), 32'(exp_g0[i]));
      check("t2_write", 32'(fifo_write), 1);
      check("t2_wdata", 32'(fifo_wdata), 32'(exp_w[i]));
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Backpressure on full, resumption opposite the last winner, statistics
    do_reset();
    req0 = 1'b1; data0 = 4'h3;
    @(negedge clk);
    check("t3_pre_gnt0", 32'(gnt0), 1);
    next_cycle();
    force_full = 1'b1;
    req1 = 1'b1; data1 = 4'h4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_full_gnt0", 32'(gnt0), 0);
      check("t3_full_gnt1", 32'(gnt1), 0);
      check("t3_full_write", 32'(fifo_write), 0);
      next_cycle();
    end
    force_full = 1'b0;
    @(negedge clk);
    check("t3_resume_gnt1", 32'(gnt1), 1);
    check("t3_resume_wdata", 32'(fifo_wdata), 32'h4);
    next_cycle();
    @(negedge clk);
    check("t3_next_gnt0", 32'(gnt0), 1);
    next_cycle();
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_solo_gnt1", 32'(gnt1), 1);
      next_cycle();
    end
    req1 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    check("t3_last_gnt0", 32'(gnt0), 1);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
`ifdef ARB_STATS_EN
    check("t3_cnt0", 32'(cnt0), 3);
    check("t3_cnt1", 32'(cnt1), 5);
    check("t3_stall", 32'(stall_cnt), 2);
`endif

    // Three words queued with a stalled consumer, then drained in order
    do_reset();
    reads = 0; hold_cycles = 0; stable_bad = 0; seen = 1'b0; hold_val = '0;
    for (int c = 0; c < 15; c++) begin
      req0 = (c < 3);
      data0 = 4'(5 + c);
      @(negedge clk);
      if (c < 3) check("t4_gnt0", 32'(gnt0), 1);
      if (fifo_read) reads++;
      if (out_valid) begin
        hold_cycles++;
        if (!seen) hold_val = out_data;
        else if (out_data != hold_val) stable_bad++;
        seen = 1'b1;
      end
      next_cycle();
    end
    req0 = 1'b0;
    check("t4_one_pop", reads, 1);
    check("t4_hold_cycles", hold_cycles, 10);
    check("t4_hold_data", 32'(hold_val), 5);
    check("t4_stable", stable_bad, 0);
    out_ready = 1'b1;
    cyc = 0;
    while (got.size() < 3 && cyc < 40) begin
      @(negedge clk);
      if (fifo_read) pops.push_back(cyc);
      if (out_valid && out_ready) got.push_back(out_data);
      next_cycle();
      cyc++;
    end
    out_ready = 1'b0;
    check("t4_delivered", got.size(), 3);
    for (int i = 0; i < 3; i++)
      check("t4_order", 32'((got.size() > i) ? got[i] : 4'hF), 32'(5 + i));
    check("t4_drain_pops", pops.size(), 2);
    if (pops.size() == 2)
      check("t4_pop_spacing", 32'((pops[1] - pops[0]) >= SETTLE + 1), 1);

    // Reset during HOLD drops the word and restores producer-0 priority
    do_reset();
    req1 = 1'b1; data1 = 4'h9;
    @(negedge clk);
    check("t5_gnt1", 32'(gnt1), 1);
    next_cycle();
    req1 = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      if (!out_valid) next_cycle();
      cyc++;
    end
    check("t5_hold_valid", 32'(out_valid), 1);
    check("t5_hold_data", 32'(out_data), 32'h9);
    req0 = 1'b1; data0 = 4'h6;
    req1 = 1'b1; data1 = 4'h7;
    reset = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 0);
    check("t5_rst_gnt0", 32'(gnt0), 0);
    check("t5_rst_gnt1", 32'(gnt1), 0);
    check("t5_rst_write", 32'(fifo_write), 0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("t5_tie_gnt0", 32'(gnt0), 1);
    check("t5_tie_gnt1", 32'(gnt1), 0);
    check("t5_idle_valid", 32'(out_valid), 0);
    check("t5_idle_read", 32'(fifo_read), 0);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
